misr_sig_ctrl: RTL and testbench

MISR_SIG_CTRL -- requirements
Module: misr_sig_ctrl

---
 rtl/misr_ctrl_pkg.sv | 15 +
 rtl/misr_sig_ctrl.sv | 124 ++++++++++++
 tb/tb_misr_sig_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/misr_ctrl_pkg.sv
// Shared types and constants for the MISR signature controller.
package misr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_CHECK,
        ST_DONE
    } state_e;

    // Value the MISR loads while misr_clr_n is low; users take the low N bits.
    localparam logic [63:0] MISR_SEED = 64'd1;

endpackage

// File: rtl/misr_sig_ctrl.sv
// Sequences one MISR compaction run: clear, count valid samples, compare
// the final signature against the golden value and pulse done.
module misr_sig_ctrl
    import misr_ctrl_pkg::*;
#(
    parameter int N     = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [N-1:0]     cfg_coeff,
    input  logic [N-1:0]     cfg_golden,
    input  logic             sample_valid,
    input  logic [N-1:0]     misr_sig,
    output logic             misr_en,
    output logic             misr_clr_n,
    output logic [N-1:0]     misr_coeff,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N-1:0]     sig_out
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [N-1:0]     coeff_q, coeff_d;
    logic [N-1:0]     golden_q, golden_d;
    logic             pass_q, pass_d;
    logic [N-1:0]     sig_q, sig_d;

    // State, counter, latched configuration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            len_q    <= '0;
            coeff_q  <= '0;
            golden_q <= '0;
            pass_q   <= 1'b0;
            sig_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            len_q    <= len_d;
            coeff_q  <= coeff_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
            sig_q    <= sig_d;
        end
    end

    // Next-state, sample counting, result capture and per-state outputs.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_d    = len_q;
        coeff_d  = coeff_q;
        golden_d = golden_q;
        pass_d   = pass_q;
        sig_d    = sig_q;
        misr_en  = 1'b0;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d    = cfg_len;
                    coeff_d  = cfg_coeff;
                    golden_d = cfg_golden;
                    count_d  = '0;
                    pass_d   = 1'b0;
                    sig_d    = '0;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (len_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                misr_en = sample_valid;
                // Abort takes priority over a sample, even the final one.
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (sample_valid) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_q == len_q - CNT_W'(1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                sig_d   = misr_sig;
                pass_d  = (misr_sig == golden_q);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign misr_clr_n = !(rst || (state_q == ST_CLEAR));
    assign misr_coeff = coeff_q;
    assign pass       = pass_q;
    assign sig_out    = sig_q;

endmodule

// File: tb/tb_misr_sig_ctrl.sv
// Directed bench for misr_sig_ctrl with a behavioural MISR beside the DUT.
module tb_misr_sig_ctrl;
    import misr_ctrl_pkg::*;

    localparam int N     = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_len;
    logic [N-1:0]     cfg_coeff;
    logic [N-1:0]     cfg_golden;
    logic             sample_valid;
    logic [N-1:0]     misr_sig;
    logic             misr_en;
    logic             misr_clr_n;
    logic [N-1:0]     misr_coeff;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N-1:0]     sig_out;

    logic [N-1:0]     mdata;
    logic [N-1:0]     env_sig;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int en_cnt   = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    typedef struct packed {
        logic         p;
        logic [N-1:0] s;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    misr_sig_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_len      (cfg_len),
        .cfg_coeff    (cfg_coeff),
        .cfg_golden   (cfg_golden),
        .sample_valid (sample_valid),
        .misr_sig     (misr_sig),
        .misr_en      (misr_en),
        .misr_clr_n   (misr_clr_n),
        .misr_coeff   (misr_coeff),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .sig_out      (sig_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] mstep(input logic [N-1:0] s, input logic [N-1:0] c,
                                           input logic [N-1:0] d);
        return {s[N-2:0], 1'b0} ^ (s[N-1] ? c : '0) ^ d;
    endfunction

    // Behavioural MISR driven by the controller's enables.
    always @(posedge clk) begin
        if (!misr_clr_n) env_sig <= MISR_SEED[N-1:0];
        else if (misr_en) env_sig <= mstep(env_sig, misr_coeff, mdata);
    end
    assign misr_sig = env_sig;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: count enables, pop the scoreboard on each done pulse.
    always @(negedge clk) begin
        if (misr_en === 1'b1) en_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("pass", 32'(pass), 32'(mon_e.p));
                chk("sig_out", 32'(sig_out), 32'(mon_e.s));
            end else begin
                chk("spurious_done", 32'(done), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int prev, input int bound);
        int n = 0;
        while (done_cnt == prev && n < bound) begin
            step();
            n++;
        end
        chk("done_seen", 32'(done_cnt - prev), 32'd1);
    endtask

    task automatic do_run(input int len, input logic [N-1:0] coeff, input logic [N-1:0] gxor,
                          input logic [15:0] pat, input int plen);
        logic [N-1:0] d[16];
        logic [N-1:0] e;
        int nv, prev, en0, start_cyc, last_cyc, got;
        e  = MISR_SEED[N-1:0];
        nv = 0;
        for (int i = 0; i < plen; i++) begin
            d[i] = N'($urandom);
            if (pat[i] && nv < len) begin
                e = mstep(e, coeff, d[i]);
                nv++;
            end
        end
        sb_q.push_back('{p: (gxor == '0), s: e});
        prev = done_cnt;
        en0  = en_cnt;
        last_cyc = 0;
        cfg_len = CNT_W'(len);
        cfg_coeff = coeff;
        cfg_golden = e ^ gxor;
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        sample_valid = 1'b1;
        mdata = N'($urandom);
        #1;
        chk("clear_clr_n", 32'(misr_clr_n), 32'd0);
        chk("clear_en", 32'(misr_en), 32'd0);
        chk("clear_busy", 32'(busy), 32'd1);
        step();
        sample_valid = 1'b0;
        got = 0;
        if (len > 0) begin
            for (int i = 0; i < plen && got < len; i++) begin
                sample_valid = pat[i];
                mdata = d[i];
                #1;
                chk("en_mirror", 32'(misr_en), 32'(pat[i]));
                chk("coeff_out", 32'(misr_coeff), 32'(coeff));
                if (pat[i]) begin
                    got++;
                    if (got == len) last_cyc = cyc;
                end
                step();
            end
        end
        sample_valid = 1'b0;
        wait_done(prev, 20);
        if (len == 0) chk("latency", 32'(done_cyc - start_cyc), 32'd3);
        else chk("latency", 32'(done_cyc - last_cyc), 32'd2);
        repeat (3) step();
        chk("one_done", 32'(done_cnt - prev), 32'd1);
        chk("en_count", 32'(en_cnt - en0), 32'(len));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("sig_hold", 32'(sig_out), 32'(e));
    endtask

    initial begin
        int prev;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_len = '0;
        cfg_coeff = '0;
        cfg_golden = '0;
        sample_valid = 1'b1;
        mdata = '0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_sig", 32'(sig_out), 32'd0);
        chk("rst_clr_n", 32'(misr_clr_n), 32'd0);
        chk("rst_en", 32'(misr_en), 32'd0);
        chk("rst_coeff", 32'(misr_coeff), 32'd0);
        rst = 1'b0;
        sample_valid = 1'b0;
        step();
        chk("idle_clr_n", 32'(misr_clr_n), 32'd1);

        do_run(0, 8'h1D, 8'h00, 16'h0000, 0);
        do_run(4, 8'h1D, 8'h00, 16'h000F, 4);
        do_run(3, 8'h2B, 8'h00, 16'b101001, 6);
        do_run(5, 8'hB8, 8'h80, 16'h001F, 5);

        // Reset between runs clears a non-zero signature.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_clears_sig", 32'(sig_out), 32'd0);
        step();

        // Abort after two of five samples; start in RUN must not relatch len.
        prev = done_cnt;
        cfg_len = 16'd5;
        cfg_coeff = 8'h1D;
        cfg_golden = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        cfg_len = 16'd1;
        sample_valid = 1'b0;
        step();
        start = 1'b0;
        cfg_len = 16'd0;
        for (int i = 0; i < 2; i++) begin
            sample_valid = 1'b1;
            mdata = N'($urandom);
            #1;
            chk("abort_run_en", 32'(misr_en), 32'd1);
            step();
        end
        sample_valid = 1'b1;
        #1;
        chk("abort_still_run", 32'(misr_en), 32'd1);
        chk("abort_coeff", 32'(misr_coeff), 32'h1D);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_en", 32'(misr_en), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_sig", 32'(sig_out), 32'd0);
        sample_valid = 1'b0;
        repeat (4) step();
        chk("abort_no_done", 32'(done_cnt - prev), 32'd0);

        // Abort coinciding with the final sample wins.
        prev = done_cnt;
        cfg_len = 16'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        sample_valid = 1'b1;
        mdata = N'($urandom);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        sample_valid = 1'b0;
        #1;
        chk("abort_final_busy", 32'(busy), 32'd0);
        repeat (4) step();
        chk("abort_final_no_done", 32'(done_cnt - prev), 32'd0);

        // Reset in the middle of RUN.
        prev = done_cnt;
        cfg_len = 16'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        sample_valid = 1'b1;
        repeat (2) begin
            mdata = N'($urandom);
            step();
        end
        rst = 1'b1;
        #1;
        chk("midrst_clr_n", 32'(misr_clr_n), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_en", 32'(misr_en), 32'd0);
        chk("midrst_sig", 32'(sig_out), 32'd0);
        sample_valid = 1'b0;
        repeat (4) step();
        chk("midrst_no_done", 32'(done_cnt - prev), 32'd0);

        do_run(2, 8'h8E, 8'h00, 16'h0003, 2);

        repeat (3) step();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
